ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain loader that sits directly upstream of a tile's `ccff_head` and downstream of its `ccff_tail`. It accepts bitstream words over a valid/ready stream, serialises them one bit per enabled `prog_clk` cycle into the chain head, and drives a clock-enable that the top level uses to gate `prog_clk` to the fabric. It packs the bits emerging from `ccff_tail`, which are the previous chain contents, into readback words. It asserts `done` once exactly `CHAIN_LEN` bits have been shifted.

## Interface
Parameters:
- `WORD_W`, default 8: bitstream and readback word width.
- `CHAIN_LEN`, default 64: total flops in the downstream chain; must be ≥1 and need not be a multiple of `WORD_W`.
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of the bit counter.

Ports:
- `prog_clk`  in  1  single clock, rising edge.
- `pReset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled in IDLE or DONE.
- `bs_valid`  in  1  bitstream word valid.
- `bs_data`  in  `WORD_W`  bitstream word; bit 0 is shifted first.
- `bs_ready`  out  1  loader can take a word.
- `ccff_head`  out  1  serial bit into the chain.
- `ccff_tail`  in  1  serial bit out of the chain.
- `prog_clk_en`  out  1  fabric chain advances on this edge.
- `rb_valid`  out  1  one-cycle pulse; `rb_data` valid.
- `rb_data`  out  `WORD_W`  readback word; bit 0 is the first bit out of the tail.
- `busy`  out  1  state is LOAD.
- `done`  out  1  state is DONE.
- `err`  out  1  sticky flag: `start` was seen while busy.

## Operation
- States and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → DONE when `bits_left` reaches 0.
  - DONE → LOAD on `start`.
  - No other transitions.
- Entering LOAD loads `bits_left = CHAIN_LEN`, `sr_cnt = 0` and the readback bit index 0.
- `bs_ready = LOAD && bits_left>sr_cnt && (sr_cnt==0 || (sr_cnt==1 && prog_clk_en))`. Back-to-back words therefore cause no bubble.
- Word accept (`bs_valid && bs_ready`):
  - `sr <= bs_data`.
  - `sr_cnt <= min(WORD_W, bits_left - sr_cnt)`, with `bits_left` taken after any shift in the same cycle.
  - Surplus high bits of the final word are discarded.
- `prog_clk_en = LOAD && sr_cnt!=0`. It is a pure decode of flops, with no path from any input.
- `ccff_head = sr[0]`, driven from a flop.
- On each cycle with `prog_clk_en=1`:
  - `sr >>= 1`.
  - `sr_cnt`−1 and `bits_left`−1.
  - The current `ccff_tail` is stored at the readback index, and the index is incremented.
- Readback: `rb_valid` pulses when the index reaches `WORD_W`, or when the final bit of the load is captured. A partial last word is zero-padded in its high bits.
- A bitstream underrun is not an error: `prog_clk_en` stays low and the chain holds.
- `start` while in LOAD is ignored and sets `err`. `err` clears when `start` is accepted in IDLE or DONE.
- Words offered after the last bit are never accepted; `bs_ready` stays 0.

## Timing
- Reset values: `bs_ready=0`, `ccff_head=0`, `prog_clk_en=0`, `rb_valid=0`, `rb_data=0`, `busy=0`, `done=0`, `err=0`. State is IDLE.
- Reset asserted mid-load clears all state immediately. `prog_clk_en` falls without waiting for a clock edge, so the chain contents are undefined and a reload is required.
- Latency:
  - `start` sampled at edge 0 → `busy=1` and `bs_ready=1` after edge 0.
  - A word accepted at edge 1 → `prog_clk_en=1` from edge 1 to edge 2.
  - The first chain shift is at edge 2.
- With no stalls, a full load takes `CHAIN_LEN+2` cycles from `start` to `done`.
- `done` rises the cycle after the last enabled shift, which is the same edge that issues the final `rb_valid`.
- The fabric samples `ccff_head` on every edge where `prog_clk_en=1`. The loader samples `ccff_tail` on that same edge, before the chain shifts.

## Structure
- Package `ccff_loader_pkg`:
  - enum `ccff_ld_state_e` with values IDLE, LOAD, DONE.
  - function `ccff_words(len, w)` returning ceil(len/w), for bench word counting.
- Sub-module `ccff_rb_packer`: serial-to-parallel readback packing, with a flush-on-last input. The main module holds the FSM, the counters and the shift register.

## Test plan
- Shift pattern, `CHAIN_LEN=20`, `WORD_W=8`, words 0xA5, 0x3C, 0x0F, no stalls:
  - Required: exactly 20 enabled shifts.
  - Required: `ccff_head` sequence 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0, then 1,1,1,1.
  - Required: `done` at cycle 22; the fourth word is never accepted.
- Readback, with the chain model's prior contents all-ones:
  - Required: `rb_valid` pulses carry 0xFF, 0xFF, then 0x0F with zero pad.
  - Required: a second load of the same data reads back 0xA5, 0x3C, 0x0F.
- Stalls: drop `bs_valid` for 5 cycles between words 1 and 2.
  - Required: `prog_clk_en=0` for those cycles.
  - Required: shifted data is identical and `done` moves to cycle 27.
- `start` pulsed while in LOAD:
  - Required: `err=1`, and the load completes unchanged.
  - Required: the next `start` from DONE clears `err`.
- Reset driven low at shift 9:
  - Required: all outputs are 0 immediately and the state is IDLE.
  - Required: `start` then performs a full 20-bit load correctly.
- `CHAIN_LEN=1`, word 0xFE:
  - Required: a single enabled shift with `ccff_head=0`.
  - Required: `rb_valid` carries the tail bit in bit 0 and `done` rises.

Source files
------------

// File: rtl/ccff_chain_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ccff_loader_pkg
// Brief    : State encoding and word-count helper shared by the chain loader
// Revision : 1.0 - initial release
// ============================================================================
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ccff_ld_state_e;

    // Number of WORD_W-wide words needed to cover a chain of len bits.
    function automatic int ccff_words(input int len, input int w);
        return (len + w - 1) / w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_rb_packer.sv
`default_nettype none
// ============================================================================
// Module   : ccff_rb_packer
// Brief    : Packs serial chain-tail bits into readback words, LSB first
// Revision : 1.0 - initial release
// ============================================================================
module ccff_rb_packer #(
    parameter int WORD_W = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              clear,
    input  logic              cap_en,
    input  logic              cap_bit,
    input  logic              cap_last,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data
);

    localparam int               IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] merged;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rb_valid_q, rb_valid_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;

    always_comb begin
        acc_d         = acc_q;
        idx_d         = idx_q;
        rb_valid_d    = 1'b0;
        rb_data_d     = rb_data_q;
        merged        = acc_q;
        merged[idx_q] = cap_bit;
        if (clear) begin
            acc_d = '0;
            idx_d = '0;
        end else if (cap_en) begin
            // The accumulator is zeroed after each emit, so a flushed
            // partial word carries zeros in its unused high bits.
            if ((idx_q == IDX_LAST) || cap_last) begin
                rb_valid_d = 1'b1;
                rb_data_d  = merged;
                acc_d      = '0;
                idx_d      = '0;
            end else begin
                acc_d = merged;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            acc_q      <= '0;
            idx_q      <= '0;
            rb_valid_q <= 1'b0;
            rb_data_q  <= '0;
        end else begin
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            rb_valid_q <= rb_valid_d;
            rb_data_q  <= rb_data_d;
        end
    end

    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_data_q;

endmodule
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : ccff_chain_loader
// Brief    : Serialises bitstream words into a config chain and reads back
//            the previous chain contents from its tail
// Revision : 1.0 - initial release
// ============================================================================
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              bs_valid,
    input  logic [WORD_W-1:0] bs_data,
    output logic              bs_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              prog_clk_en,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int               SC_W     = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN_INIT = CNT_W'(CHAIN_LEN);
    localparam logic [SC_W-1:0]  WORD_CNT = SC_W'(WORD_W);

    ccff_ld_state_e    state_q, state_d;
    logic [CNT_W-1:0]  bits_left_q, bits_left_d;
    logic [SC_W-1:0]   sr_cnt_q, sr_cnt_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic              err_q, err_d;
    logic              shift, accept, load_go, last_bit;

    // Clock enable decodes flops only so the fabric gate has no input path.
    assign prog_clk_en = (state_q == LOAD) && (sr_cnt_q != '0);
    assign bs_ready    = (state_q == LOAD)
                      && (32'(bits_left_q) > 32'(sr_cnt_q))
                      && ((sr_cnt_q == '0) || ((sr_cnt_q == SC_W'(1)) && prog_clk_en));

    assign shift     = prog_clk_en;
    assign accept    = bs_valid && bs_ready;
    assign load_go   = start && (state_q != LOAD);
    assign last_bit  = shift && (bits_left_q == CNT_W'(1));
    assign ccff_head = sr_q[0];
    assign busy      = (state_q == LOAD);
    assign done      = (state_q == DONE);
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        sr_cnt_d    = sr_cnt_q;
        sr_d        = sr_q;
        err_d       = err_q;

        if (shift) begin
            sr_d        = sr_q >> 1;
            sr_cnt_d    = sr_cnt_q - SC_W'(1);
            bits_left_d = bits_left_q - CNT_W'(1);
        end

        // The new word's valid count is clipped to the bits still owed to
        // the chain, which silently drops surplus bits of the last word.
        if (accept) begin
            sr_d = bs_data;
            if (32'(bits_left_d) >= 32'(WORD_W)) begin
                sr_cnt_d = WORD_CNT;
            end else begin
                sr_cnt_d = SC_W'(bits_left_d);
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = LOAD;
                    bits_left_d = LEN_INIT;
                    sr_cnt_d    = '0;
                    err_d       = 1'b0;
                end
            end
            LOAD: begin
                if (start) begin
                    err_d = 1'b1;
                end
                if (bits_left_d == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q     <= IDLE;
            bits_left_q <= '0;
            sr_cnt_q    <= '0;
            sr_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            sr_cnt_q    <= sr_cnt_d;
            sr_q        <= sr_d;
            err_q       <= err_d;
        end
    end

    ccff_rb_packer #(
        .WORD_W (WORD_W)
    ) u_rb_packer (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clear    (load_go),
        .cap_en   (shift),
        .cap_bit  (ccff_tail),
        .cap_last (last_bit),
        .rb_valid (rb_valid),
        .rb_data  (rb_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccff_chain_loader
// Brief    : Directed self-checking bench for the config-chain loader
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccff_chain_loader;
    import ccff_loader_pkg::*;

    localparam logic [19:0] EXP_HEADS = 20'hF3CA5;

    logic       clk = 1'b0;
    logic       pReset;
    logic       start, bs_valid, bs_ready, ccff_head, ccff_tail, prog_clk_en;
    logic       rb_valid, busy, done, err;
    logic [7:0] bs_data, rb_data;

    logic       start1, bs_valid1, bs_ready1, head1, tail1, en1;
    logic       rb_valid1, busy1, done1, err1;
    logic [7:0] bs_data1, rb_data1;

    int errors = 0;
    int checks = 0;

    logic [7:0]  words [4];
    logic [19:0] chain;
    logic [19:0] heads_v;
    logic [7:0]  rb_w [4];
    int          n_shift, n_rb, n_acc, done_cyc, gap, err_c1;
    logic        err_end;

    always #5 clk = ~clk;

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut (
        .prog_clk(clk), .pReset(pReset), .start(start), .bs_valid(bs_valid),
        .bs_data(bs_data), .bs_ready(bs_ready), .ccff_head(ccff_head),
        .ccff_tail(ccff_tail), .prog_clk_en(prog_clk_en), .rb_valid(rb_valid),
        .rb_data(rb_data), .busy(busy), .done(done), .err(err)
    );

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(1)) dut1 (
        .prog_clk(clk), .pReset(pReset), .start(start1), .bs_valid(bs_valid1),
        .bs_data(bs_data1), .bs_ready(bs_ready1), .ccff_head(head1),
        .ccff_tail(tail1), .prog_clk_en(en1), .rb_valid(rb_valid1),
        .rb_data(rb_data1), .busy(busy1), .done(done1), .err(err1)
    );

    // Bits leave the tail in order chain[19], chain[18], ...; word k bit j is
    // the (8k+j)-th bit out, zero past the chain length.
    function automatic logic [7:0] exp_rb(input logic [19:0] pre, input int k);
        logic [7:0] b;
        b = '0;
        for (int j = 0; j < 8; j++) begin
            if (8 * k + j < 20) b[j] = pre[19 - (8 * k + j)];
        end
        return b;
    endfunction

    // Runs one load from IDLE/DONE, entered and left on a falling edge.
    task automatic drive_load(input int stall_n, input int mid_start_cyc, input int abort_at);
        int   cyc, stall_left, first_en, last_en, post;
        bit   stall_done;
        logic en_s, head_s, hs;
        n_shift = 0; n_rb = 0; n_acc = 0; done_cyc = -1; gap = -1; err_c1 = -1;
        heads_v = '0;
        for (int i = 0; i < 4; i++) rb_w[i] = 'x;
        cyc = 0; stall_left = 0; stall_done = 0; first_en = -1; last_en = -1; post = 0;
        start = 1'b1; bs_valid = 1'b0;
        while (cyc < 100 && post < 4) begin
            en_s = prog_clk_en; head_s = ccff_head; hs = bs_valid && bs_ready;
            if (en_s) begin
                if (n_shift < 20) heads_v[n_shift] = head_s;
                n_shift++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            @(posedge clk);
            cyc++;
            if (en_s) chain = {chain[18:0], head_s};
            if (hs) n_acc++;
            @(negedge clk);
            ccff_tail = chain[19];
            start = (cyc == mid_start_cyc);
            if (rb_valid) begin
                if (n_rb < 4) rb_w[n_rb] = rb_data;
                n_rb++;
            end
            if (cyc == 1) err_c1 = int'(err);
            if (done_cyc < 0 && done) done_cyc = cyc;
            if (done_cyc >= 0) post++;
            if (abort_at > 0 && n_shift >= abort_at) break;
            if (stall_n > 0 && !stall_done && n_acc == 1 && bs_ready) begin
                stall_left = stall_n;
                stall_done = 1;
            end
            if (stall_left > 0) begin
                bs_valid = 1'b0;
                stall_left--;
            end else if (n_acc < 4) begin
                bs_valid = 1'b1;
                bs_data  = words[n_acc];
            end else begin
                bs_valid = 1'b0;
            end
        end
        if (first_en >= 0) gap = last_en - first_en + 1 - n_shift;
        err_end = err;
        if (abort_at == 0) begin
            bs_valid = 1'b0;
            start    = 1'b0;
        end
    endtask

    task automatic test_reset();
        pReset = 1'b0; start = 0; bs_valid = 0; bs_data = '0;
        chain = '1; ccff_tail = 1'b1;
        start1 = 0; bs_valid1 = 0; bs_data1 = '0; tail1 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bs_ready, ccff_head, prog_clk_en, rb_valid, busy, done, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {bs_ready, ccff_head, prog_clk_en, rb_valid, busy, done, err});
        end
        checks++;
        if (rb_data !== 8'h00) begin
            errors++; $display("FAIL reset_rb_data: got %h want 00", rb_data);
        end
        pReset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, bs_ready, prog_clk_en} !== 4'b0) begin
            errors++; $display("FAIL idle_after_reset: got %b want 0000", {busy, done, bs_ready, prog_clk_en});
        end
        checks++;
        if ({busy1, done1, bs_ready1, en1, rb_valid1, err1} !== 6'b0) begin
            errors++; $display("FAIL reset_len1: got %b want 000000", {busy1, done1, bs_ready1, en1, rb_valid1, err1});
        end
    endtask

    task automatic test_shift_pattern();
        drive_load(0, 0, 0);
        checks++;
        if (n_shift !== 20) begin errors++; $display("FAIL shift_count: got %0d want 20", n_shift); end
        checks++;
        if (heads_v !== EXP_HEADS) begin errors++; $display("FAIL head_seq: got %h want %h", heads_v, EXP_HEADS); end
        checks++;
        if (done_cyc !== 22) begin errors++; $display("FAIL done_cycle: got %0d want 22", done_cyc); end
        checks++;
        if (n_acc !== ccff_words(20, 8)) begin errors++; $display("FAIL words_accepted: got %0d want 3", n_acc); end
        checks++;
        if (gap !== 0) begin errors++; $display("FAIL no_bubble: got %0d idle cycles want 0", gap); end
        checks++;
        if (n_rb !== 3) begin errors++; $display("FAIL rb_count: got %0d want 3", n_rb); end
        checks++;
        if ({rb_w[0], rb_w[1], rb_w[2]} !== 24'hFFFF0F) begin
            errors++; $display("FAIL rb_ones: got %h %h %h want ff ff 0f", rb_w[0], rb_w[1], rb_w[2]);
        end
        checks++;
        if ({busy, done} !== 2'b01) begin errors++; $display("FAIL end_state: got busy/done %b want 01", {busy, done}); end
    endtask

    task automatic test_readback_second();
        drive_load(0, 0, 0);
        checks++;
        if ({rb_w[0], rb_w[1], rb_w[2]} !== 24'hA53C0F || n_rb !== 3) begin
            errors++; $display("FAIL rb_second: got %h %h %h (n=%0d) want a5 3c 0f (n=3)", rb_w[0], rb_w[1], rb_w[2], n_rb);
        end
        checks++;
        if (done_cyc !== 22) begin errors++; $display("FAIL done_cycle_2: got %0d want 22", done_cyc); end
    endtask

    task automatic test_stall();
        drive_load(5, 0, 0);
        checks++;
        if (gap !== 5) begin errors++; $display("FAIL stall_gap: got %0d idle cycles want 5", gap); end
        checks++;
        if (heads_v !== EXP_HEADS || n_shift !== 20) begin
            errors++; $display("FAIL stall_heads: got %h (n=%0d) want %h (n=20)", heads_v, n_shift, EXP_HEADS);
        end
        checks++;
        if (done_cyc !== 27) begin errors++; $display("FAIL stall_done_cycle: got %0d want 27", done_cyc); end
    endtask

    task automatic test_start_in_load();
        drive_load(0, 5, 0);
        checks++;
        if (err_end !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_end); end
        checks++;
        if (heads_v !== EXP_HEADS || done_cyc !== 22) begin
            errors++; $display("FAIL load_unchanged: got %h done %0d want %h done 22", heads_v, done_cyc, EXP_HEADS);
        end
        drive_load(0, 0, 0);
        checks++;
        if (err_c1 !== 0 || err_end !== 1'b0) begin
            errors++; $display("FAIL err_clear: got %0d/%b want 0/0", err_c1, err_end);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [19:0] pre;
        drive_load(0, 0, 9);
        pReset = 1'b0;
        #1;
        checks++;
        if ({bs_ready, ccff_head, prog_clk_en, rb_valid, busy, done, err} !== 7'b0 || rb_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %b rb %h want 0000000 rb 00",
                     {bs_ready, ccff_head, prog_clk_en, rb_valid, busy, done, err}, rb_data);
        end
        start = 0; bs_valid = 0;
        @(negedge clk);
        pReset = 1'b1;
        @(negedge clk);
        pre = chain;
        drive_load(0, 0, 0);
        checks++;
        if (heads_v !== EXP_HEADS || n_shift !== 20 || done_cyc !== 22) begin
            errors++; $display("FAIL reload: got %h n=%0d done %0d want %h n=20 done 22", heads_v, n_shift, done_cyc, EXP_HEADS);
        end
        checks++;
        if (rb_w[0] !== exp_rb(pre, 0) || rb_w[1] !== exp_rb(pre, 1) || rb_w[2] !== exp_rb(pre, 2)) begin
            errors++;
            $display("FAIL reload_rb: got %h %h %h want %h %h %h", rb_w[0], rb_w[1], rb_w[2],
                     exp_rb(pre, 0), exp_rb(pre, 1), exp_rb(pre, 2));
        end
    endtask

    task automatic test_chain_len1();
        int         cyc, n_en, n_acc1, n_rb1, done_c;
        logic       hd;
        logic [7:0] rbd;
        cyc = 0; n_en = 0; n_acc1 = 0; n_rb1 = 0; done_c = -1; hd = 1'bx; rbd = 'x;
        tail1 = 1'b1; start1 = 1'b1; bs_valid1 = 1'b0; bs_data1 = 8'hFE;
        while (cyc < 20 && (done_c < 0 || cyc < done_c + 3)) begin
            if (en1) begin n_en++; hd = head1; end
            if (bs_valid1 && bs_ready1) n_acc1++;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start1 = 1'b0; bs_valid1 = 1'b1;
            if (rb_valid1) begin n_rb1++; rbd = rb_data1; end
            if (done_c < 0 && done1) done_c = cyc;
        end
        bs_valid1 = 1'b0;
        checks++;
        if (n_en !== 1 || hd !== 1'b0) begin errors++; $display("FAIL len1_shift: got n=%0d head=%b want n=1 head=0", n_en, hd); end
        checks++;
        if (n_rb1 !== 1 || rbd !== 8'h01) begin errors++; $display("FAIL len1_rb: got n=%0d data=%h want n=1 data=01", n_rb1, rbd); end
        checks++;
        if (done_c !== 3 || n_acc1 !== 1) begin errors++; $display("FAIL len1_done: got done %0d acc %0d want done 3 acc 1", done_c, n_acc1); end
    endtask

    initial begin
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h0F; words[3] = 8'h77;
        test_reset();
        test_shift_pattern();
        test_readback_second();
        test_stall();
        test_start_in_load();
        test_reset_mid_load();
        test_chain_len1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
